// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : ex_muldiv
//  Purpose  : Iterative RV32M multiply/divide unit beside the EX-stage ALU.
//             Radix-2 shift-add multiply and restoring divide work on operand
//             magnitudes, one result bit per cycle. The sign fix-up is applied
//             on the edge that enters DONE. Divide-by-zero and signed overflow
//             skip the iteration and finish on the accepting edge.
//  Ports    : clk, rst (async, active high), flush (sync kill)
//             in_valid/in_ready, op[2:0] (funct3), r1, r2, rd, rd_enable
//             out_valid/out_ready, result, rd_addr_o, rd_enable_o, busy
//  Config   : MULDIV_FAST_MUL_EN - multiplies use a single-cycle combinational
//             product (latency 1); divides remain iterative.
//  Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [4:0]      rd,
  input  logic            rd_enable,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_o,
  output logic            rd_enable_o,
  output logic            busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic              neg_q;    // negate product / quotient
  logic              neg_r;    // negate remainder (dividend sign)
  logic [XLEN-1:0]   mag_b;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc;      // mul: {partial sum, multiplier}; div: low half = dividend/quotient
  logic [XLEN-1:0]   rem;      // partial remainder; always < divisor so XLEN bits hold it
  logic [CNT_W-1:0]  count;

  // Operand sign decode: op[2] selects divide, op[0] marks unsigned divide.
  logic w_sgn1, w_sgn2, w_s1, w_s2;
  logic [XLEN-1:0] w_mag1, w_mag2;
  assign w_sgn1 = op[2] ? !op[0] : (op != 3'd3);
  assign w_sgn2 = op[2] ? !op[0] : !op[1];
  assign w_s1   = w_sgn1 && r1[XLEN-1];
  assign w_s2   = w_sgn2 && r2[XLEN-1];
  assign w_mag1 = w_s1 ? (~r1 + 1'b1) : r1;
  assign w_mag2 = w_s2 ? (~r2 + 1'b1) : r2;

  logic w_accept, w_div0, w_ovf;
  logic [XLEN-1:0] w_special;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_div0   = op[2] && (r2 == '0);
  assign w_ovf    = op[2] && !op[0] && (r1 == {1'b1, {(XLEN-1){1'b0}}}) && (r2 == '1);
  // op[1] distinguishes REM* from DIV*.
  assign w_special = w_div0 ? (op[1] ? r1 : '1) : (op[1] ? '0 : r1);

  // Shift-add step: add multiplicand when the multiplier LSB is set, shift right.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_mul;
  assign w_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign w_acc_mul = {w_sum, acc[XLEN-1:1]};

  // Restoring step on an XLEN+1-bit partial remainder; a clear borrow bit
  // means the shifted remainder was >= divisor.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next, w_quo_next;
  assign w_shift    = {rem, acc[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, mag_b};
  assign w_ge       = !w_diff[XLEN];
  assign w_rem_next = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_next = {acc[XLEN-2:0], w_ge};

  // Final value with sign fix-up, used on the last CALC edge.
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;
  assign w_prod    = neg_q ? (~w_acc_mul + 1'b1) : w_acc_mul;
  assign w_quo_fix = neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign w_rem_fix = neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
  assign w_final   = op_q[2] ? (op_q[1] ? w_rem_fix : w_quo_fix)
                             : ((op_q[1:0] == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_mag, w_fast_sgn;
  logic [XLEN-1:0]   w_fast_res;
  assign w_fast_mag = (2*XLEN)'(w_mag1) * (2*XLEN)'(w_mag2);
  assign w_fast_sgn = (w_s1 ^ w_s2) ? (~w_fast_mag + 1'b1) : w_fast_mag;
  assign w_fast_res = (op[1:0] == 2'd0) ? w_fast_sgn[XLEN-1:0] : w_fast_sgn[2*XLEN-1:XLEN];
`endif

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      mag_b       <= '0;
      acc         <= '0;
      rem         <= '0;
      count       <= '0;
      result      <= '0;
      rd_addr_o   <= '0;
      rd_enable_o <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (w_accept) begin
            op_q        <= op;
            neg_q       <= w_s1 ^ w_s2;
            neg_r       <= w_s1;
            mag_b       <= w_mag2;
            acc         <= {{XLEN{1'b0}}, w_mag1};
            rem         <= '0;
            count       <= CNT_W'(XLEN);
            rd_addr_o   <= rd;
            rd_enable_o <= rd_enable && (rd != 5'd0);
            if (w_div0 || w_ovf) begin
              result <= w_special;
              state  <= ST_DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[2]) begin
              result <= w_fast_res;
              state  <= ST_DONE;
            end
`endif
            else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          count <= count - 1'b1;
          if (op_q[2]) begin
            rem             <= w_rem_next;
            acc[XLEN-1:0]   <= w_quo_next;
          end else begin
            acc <= w_acc_mul;
          end
          if (count == CNT_W'(1)) begin
            result <= w_final;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_muldiv
//  Purpose  : Self-checking bench for ex_muldiv (XLEN=32). Expected results
//             come from a plain-arithmetic RV32M reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, rd_enable;
  logic [2:0]  op;
  logic [31:0] r1, r2;
  logic [4:0]  rd;
  logic        in_ready, out_valid, rd_enable_o, busy;
  logic [31:0] result;
  logic [4:0]  rd_addr_o;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .r1(r1), .r2(r2),
    .rd(rd), .rd_enable(rd_enable),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference RV32M semantics.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    p  = 64'd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Edges after the accepting edge until out_valid is seen (0 = set by the accept edge).
  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 0;
`endif
    return XLEN;
  endfunction

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: in_ready timeout, got %b want 1", tag, in_ready);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic de, input logic [31:0] exp,
                        input int hold, input string tag);
    int lat;
    wait_ready(tag);
    op = f; r1 = a; r2 = b; rd = d; rd_enable = de; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs so results must come from captured values.
    r1 = $urandom; r2 = $urandom; rd = 5'($urandom); rd_enable = 1'($urandom); op = 3'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat != ref_lat(f, a, b)) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, ref_lat(f, a, b));
    end
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", tag, f, a, b, result, exp);
    end
    n_checks++;
    if (rd_addr_o !== d || rd_enable_o !== (de && d != 5'd0)) begin
      n_fail++;
      $display("FAIL %s rd: got %0d/%b want %0d/%b", tag, rd_addr_o, rd_enable_o, d, de && d != 5'd0);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
        n_fail++;
        $display("FAIL %s hold%0d: ov=%b ir=%b res=%h want ov=1 ir=0 res=%h", tag, i, out_valid, in_ready, result, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: ov=%b ir=%b busy=%b want 0 1 0", tag, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (result !== 32'd0 || rd_addr_o !== 5'd0 || rd_enable_o !== 1'b0 ||
        out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: res=%h rd=%0d rde=%b ov=%b busy=%b ir=%b want all 0",
               result, rd_addr_o, rd_enable_o, out_valid, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  fv[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av[12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'hFFFF_FFFE, 32'd7, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                            32'd2, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                            32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 12; i++)
      run_op(fv[i], av[i], bv[i], 5'(i + 1), 1'b1, ev[i], 0, $sformatf("dir%0d", i));
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a, b;
    int sel;
    for (int i = 0; i < 40; i++) begin
      f   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = $urandom_range(1, 15);
      if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 3) a = $urandom_range(0, 100);
      run_op(f, a, b, 5'($urandom), 1'($urandom), ref_result(f, a, b), $urandom_range(0, 2),
             $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_hold();
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b1, 32'hFFFF_FFEB, 5, "hold_mul");
    run_op(3'd5, 32'd5, 32'd0, 5'd0, 1'b1, 32'hFFFF_FFFF, 5, "hold_div0");
  endtask

  task automatic test_flush();
    int seen = 0;
    wait_ready("flush_start");
    op = 3'd5; r1 = 32'h1234_5678; r2 = 32'd3; rd = 5'd4; rd_enable = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_calc: ov=%b ir=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush_no_result: out_valid cycles got %0d want 0", seen);
    end
    // Offer with flush in IDLE: must not be accepted.
    op = 3'd7; r1 = 32'd9; r2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle_accept: busy=%b ov=%b want 0 0", busy, out_valid);
    end
    // Flush while DONE drops the held result.
    op = 3'd7; r1 = 32'd9; r2 = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    wait_ready("b2b_start");
    op = 3'd3; r1 = 32'hFFFF_FFFF; r2 = 32'hFFFF_FFFF; rd = 5'd11; rd_enable = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    // Second op offered continuously; must wait for the bubble after hand-off.
    op = 3'd5; r1 = 32'd100; r2 = 32'd7; rd = 5'd12;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (result !== 32'hFFFF_FFFE || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: res=%h ir=%b want fffffffe 0", result, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bubble: busy=%b ir=%b want 0 1", busy, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (result !== 32'd14 || lat != XLEN || rd_addr_o !== 5'd12) begin
      n_fail++;
      $display("FAIL b2b_second: res=%h lat=%0d rd=%0d want 0000000e %0d 12", result, lat, rd_addr_o, XLEN);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_ready("rstmid_start");
    op = 3'd0; r1 = 32'd123; r2 = 32'd456; rd = 5'd7; rd_enable = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #2;
    n_checks++;
    if (result !== 32'd0 || rd_addr_o !== 5'd0 || rd_enable_o !== 1'b0 ||
        out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: res=%h rd=%0d rde=%b ov=%b busy=%b ir=%b want all 0",
               result, rd_addr_o, rd_enable_o, out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_no_result: out_valid got %b want 0", out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; r1 = 32'd0; r2 = 32'd0; rd = 5'd0; rd_enable = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
